// File: rtl/ysyx_24100006_gpr_sb_if.sv
// Bundle between the ID stage and the register file / scoreboard: issue-time
// allocation, writeback, and the two operand read ports.
interface ysyx_24100006_gpr_sb_if #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32
);
    logic                  alloc_valid;
    logic [ADDR_WIDTH-1:0] alloc_rd;
    logic                  alloc_ready;
    logic                  wen;
    logic [ADDR_WIDTH-1:0] waddr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [ADDR_WIDTH-1:0] rs1;
    logic [ADDR_WIDTH-1:0] rs2;
    logic [DATA_WIDTH-1:0] rs1_data;
    logic [DATA_WIDTH-1:0] rs2_data;
    logic                  rs1_busy;
    logic                  rs2_busy;
    logic                  wb_err;

    // Pipeline side: issues allocations, writebacks and read requests.
    modport master (
        output alloc_valid, alloc_rd, wen, waddr, wdata, rs1, rs2,
        input  alloc_ready, rs1_data, rs2_data, rs1_busy, rs2_busy, wb_err
    );

    // Register file side.
    modport slave (
        input  alloc_valid, alloc_rd, wen, waddr, wdata, rs1, rs2,
        output alloc_ready, rs1_data, rs2_data, rs1_busy, rs2_busy, wb_err
    );
endinterface

// File: rtl/ysyx_24100006_gpr_sb.sv
// General-purpose register file with a per-register saturating pending-write
// counter. Two combinational read ports (optional writeback bypass), one
// synchronous writeback port, x0 hard-wired to zero.
module ysyx_24100006_gpr_sb #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 2,
    parameter int BYPASS     = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    ysyx_24100006_gpr_sb_if.slave   bus
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    logic [DATA_WIDTH-1:0] rf_q   [DEPTH];
    logic [CNT_WIDTH-1:0]  pend_q [DEPTH];
    logic                  alloc_ready_w;
    logic                  wb_err_reg;

    // x0 holds no state: it always reads zero and is never pending.
    assign rf_q[0]   = '0;
    assign pend_q[0] = '0;

    // Saturated registers refuse allocation; a same-cycle writeback does not
    // help, so there is no path from wen to alloc_ready.
    assign alloc_ready_w   = (bus.alloc_rd == '0) | (pend_q[bus.alloc_rd] != CNT_MAX);
    assign bus.alloc_ready = alloc_ready_w;

    genvar gi;
    generate
        for (gi = 1; gi < DEPTH; gi++) begin : g_reg
            logic [DATA_WIDTH-1:0] data_reg;
            logic [CNT_WIDTH-1:0]  pend_reg;
            logic [CNT_WIDTH-1:0]  pend_next;
            logic                  inc;
            logic                  dec;
            logic                  wr_sel;

            assign wr_sel = bus.wen & (bus.waddr == ADDR_WIDTH'(gi));
            assign inc    = bus.alloc_valid & alloc_ready_w & (bus.alloc_rd == ADDR_WIDTH'(gi));
            assign dec    = wr_sel & (pend_reg != '0);

            // Next pending count: issue and retire in the same cycle cancel out.
            always_comb begin
                pend_next = pend_reg;
                if (inc && !dec) begin
                    pend_next = pend_reg + CNT_WIDTH'(1);
                end else if (dec && !inc) begin
                    pend_next = pend_reg - CNT_WIDTH'(1);
                end
            end

            // Data and counter state; writeback always lands, even if unexpected.
            always_ff @(posedge clk) begin
                if (reset) begin
                    data_reg <= '0;
                    pend_reg <= '0;
                end else begin
                    if (wr_sel) begin
                        data_reg <= bus.wdata;
                    end
                    pend_reg <= pend_next;
                end
            end

            assign rf_q[gi]   = data_reg;
            assign pend_q[gi] = pend_reg;
        end
    endgenerate

    logic [ADDR_WIDTH-1:0] rs_idx  [2];
    logic [DATA_WIDTH-1:0] rs_data [2];
    logic                  rs_busy [2];

    assign rs_idx[0] = bus.rs1;
    assign rs_idx[1] = bus.rs2;

    generate
        for (gi = 0; gi < 2; gi++) begin : g_port
            logic fwd;
            logic hit;

            // A same-cycle writeback forwards its data and retires one pending
            // write from the busy view; allocations never affect the read side.
            assign fwd = (BYPASS != 0) & bus.wen & (bus.waddr == rs_idx[gi]);
            assign hit = fwd & (pend_q[rs_idx[gi]] != '0);

            // Read mux: x0, then bypass, then stored value.
            always_comb begin
                if (rs_idx[gi] == '0) begin
                    rs_data[gi] = '0;
                end else if (fwd) begin
                    rs_data[gi] = bus.wdata;
                end else begin
                    rs_data[gi] = rf_q[rs_idx[gi]];
                end
            end

            assign rs_busy[gi] = (pend_q[rs_idx[gi]] - CNT_WIDTH'(hit)) != '0;
        end
    endgenerate

    assign bus.rs1_data = rs_data[0];
    assign bus.rs2_data = rs_data[1];
    assign bus.rs1_busy = rs_busy[0];
    assign bus.rs2_busy = rs_busy[1];

    // One-cycle flag for a writeback that had no matching allocation.
    always_ff @(posedge clk) begin
        if (reset) begin
            wb_err_reg <= 1'b0;
        end else begin
            wb_err_reg <= bus.wen & (bus.waddr != '0) & (pend_q[bus.waddr] == '0);
        end
    end

    assign bus.wb_err = wb_err_reg;
endmodule

// File: doc/ysyx_24100006_gpr_sb.md
Name: ysyx_24100006_gpr_sb

Overview:
Parametrised general-purpose register file with an integrated per-register scoreboard, for the pipelined core's ID stage. It provides two asynchronous read ports with write-through bypass, and one synchronous write (writeback) port. x0 is hard-wired to zero. Each architectural register carries a saturating pending-write counter, incremented at issue and decremented at writeback, so ID can detect RAW hazards and stall on WAW overflow.

Parameters:
ADDR_WIDTH, 4, register index width; DEPTH = 2**ADDR_WIDTH registers (x0..x(DEPTH-1)).
DATA_WIDTH, 32, register data width.
CNT_WIDTH, 2, pending counter width per register; max outstanding writes per register = 2**CNT_WIDTH-1.
BYPASS, 1, 1 = same-cycle writeback data forwarded to read ports; 0 = read returns stored value only.

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  synchronous active-high reset
alloc_valid  in  1  issue stage requests to mark alloc_rd as pending write
alloc_rd  in  ADDR_WIDTH  destination register being allocated
alloc_ready  out  1  allocation accepted this cycle (combinational)
wen  in  1  writeback valid
waddr  in  ADDR_WIDTH  writeback destination
wdata  in  DATA_WIDTH  writeback data
rs1  in  ADDR_WIDTH  read port 1 index
rs2  in  ADDR_WIDTH  read port 2 index
rs1_data  out  DATA_WIDTH  read port 1 data (combinational)
rs2_data  out  DATA_WIDTH  read port 2 data (combinational)
rs1_busy  out  1  rs1 still has outstanding writes (combinational)
rs2_busy  out  1  rs2 still has outstanding writes (combinational)
wb_err  out  1  registered pulse: writeback hit a register whose pending count was 0

Behaviour:
- Storage: only x1..x(DEPTH-1) hold data. x0 reads 0 and is never busy. Writes and allocs to x0 are dropped.
- Reset (sync, takes priority over every input): all data registers = 0, all pending counters = 0, wb_err = 0. alloc_ready follows its combinational rule, so it is 1 with a cleared scoreboard. A reset mid-operation discards every in-flight allocation.
- Write: if wen and waddr != 0, rf[waddr] <= wdata at the edge. A write is always performed, even when pending[waddr] == 0.
- Counter update per register r, evaluated at the edge:
  - inc = alloc_valid & alloc_ready & (alloc_rd == r) & (r != 0).
  - dec = wen & (waddr == r) & (r != 0) & (pending[r] != 0).
  - inc & dec → unchanged. inc only → +1. dec only → -1.
- alloc_ready = (alloc_rd == 0) | (pending[alloc_rd] != max). Alloc to a saturated register is refused and the counter is held. A same-cycle writeback to that register does NOT raise alloc_ready; no combinational path from wen to alloc_ready.
- Underflow: wen to r != 0 with pending[r] == 0 → data written, counter stays 0, wb_err = 1 next cycle for exactly one cycle. wen to x0 never flags.
- Read data (per port, rsN):
  - rsN == 0 → 0.
  - BYPASS=1 and wen and waddr == rsN → wdata.
  - Otherwise rf[rsN].
- Busy (per port): rsN_busy = (pending[rsN] - hit) != 0, where hit = wen & waddr == rsN & pending[rsN] != 0. With BYPASS=0, hit is forced to 0. A same-cycle alloc never affects busy or data (the alloc belongs to a younger instruction).
- Latency: reads and busy are 0-cycle. Writes and counter changes are visible on the cycle after the edge.
- Both read ports are independent and may address the same register.

Test Plan:
- Reset then read: assert reset 1 cycle; rs1=5, rs2=0 → rs1_data=0, rs2_data=0, both busy=0, alloc_ready=1, wb_err=0.
- Alloc/writeback: alloc x3 at cycle 0 → rs1=3 busy=1 from cycle 1. At cycle 3, wen waddr=3 wdata=0xDEADBEEF → same cycle (BYPASS=1) rs1_data=0xDEADBEEF, busy=0. Cycle 4: stored value 0xDEADBEEF, busy=0.
- WAW saturation (CNT_WIDTH=2): alloc x7 three times → alloc_ready=0 on the 4th try and count stays 3. Add wen x7 the same cycle → count becomes 2 next cycle, alloc_ready=1.
- Simultaneous alloc and wb to x9 with pending=1 → pending stays 1, rs1_busy (rs1=9) = 0 in that cycle, 1 the next.
- x0: alloc x0 and wen waddr=0 wdata=0x1234 → alloc_ready=1, rs1=0 data=0 busy=0, wb_err stays 0.
- Underflow plus reset mid-flight: wen x4 with pending 0 → wb_err=1 for exactly one cycle and x4 updated. Alloc x4, then reset → x4=0, busy=0, and a later wen x4 raises wb_err.
